// File: rtl/hash_nonce_ctrl.sv
// Nonce-sweep sequencer for one 32-round hash core: runs the core per nonce, compares hash2 to target, reports first hit.
// 34 cycles per try (32 RUN + SETTLE + CHECK) plus one DONE cycle; start is ignored while busy, abort returns to IDLE silently.
module hash_nonce_ctrl #(
   parameter int MAX_TRIES = 16,
   parameter int TIMEOUT   = 40
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        start_i,
   input  logic        abort_i,
   input  logic [7:0]  nonce_init_i,
   input  logic [7:0]  target_i,
   input  logic [4:0]  core_cnt_i,
   input  logic [7:0]  core_hash0_i,
   input  logic [7:0]  core_hash1_i,
   input  logic [7:0]  core_hash2_i,
   output logic        core_run_o,
   output logic [7:0]  core_nonce_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        found_o,
   output logic        timeout_err_o,
   output logic [7:0]  nonce_out_o,
   output logic [23:0] hash_out_o
);

   localparam int              TW       = $clog2(TIMEOUT);
   localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);
   localparam logic [7:0]      LAST_TRY = 8'(MAX_TRIES - 1);

   typedef enum logic [2:0] {S_IDLE, S_RUN, S_SETTLE, S_CHECK, S_DONE} state_t;

   state_t        state_q, state_d;
   logic          core_run_q, core_run_d;
   logic [7:0]    core_nonce_q, core_nonce_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          found_q, found_d;
   logic          tmo_err_q, tmo_err_d;
   logic [7:0]    nonce_out_q, nonce_out_d;
   logic [23:0]   hash_out_q, hash_out_d;
   logic [7:0]    target_q, target_d;
   logic [7:0]    tries_q, tries_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [23:0]   hash_cur;

   assign hash_cur = {core_hash2_i, core_hash1_i, core_hash0_i};

   always_comb begin
      state_d      = state_q;
      core_run_d   = core_run_q;
      core_nonce_d = core_nonce_q;
      found_d      = found_q;
      tmo_err_d    = tmo_err_q;
      nonce_out_d  = nonce_out_q;
      hash_out_d   = hash_out_q;
      target_d     = target_q;
      tries_d      = tries_q;
      tmo_d        = tmo_q;

      case (state_q)
         S_IDLE: begin
            core_run_d = 1'b0;
            if (start_i && !abort_i) begin
               target_d     = target_i;
               core_nonce_d = nonce_init_i;
               tries_d      = 8'd0;
               tmo_d        = '0;
               found_d      = 1'b0;
               tmo_err_d    = 1'b0;
               nonce_out_d  = 8'd0;
               hash_out_d   = 24'd0;
               core_run_d   = 1'b1;
               state_d      = S_RUN;
            end
         end
         S_RUN: begin
            if (core_cnt_i == 5'd31) begin
               state_d = S_SETTLE;
            end else if (tmo_q == TMO_LAST) begin
               tmo_err_d   = 1'b1;
               found_d     = 1'b0;
               nonce_out_d = core_nonce_q;
               core_run_d  = 1'b0;
               state_d     = S_DONE;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         S_SETTLE: begin
            // Core captures its final hash on this edge; drop run so it clears next.
            core_run_d = 1'b0;
            state_d    = S_CHECK;
         end
         S_CHECK: begin
            if (core_hash2_i < target_q) begin
               found_d     = 1'b1;
               nonce_out_d = core_nonce_q;
               hash_out_d  = hash_cur;
               state_d     = S_DONE;
            end else if (tries_q == LAST_TRY) begin
               found_d     = 1'b0;
               nonce_out_d = core_nonce_q;
               hash_out_d  = hash_cur;
               state_d     = S_DONE;
            end else begin
               tries_d      = tries_q + 8'd1;
               core_nonce_d = core_nonce_q + 8'd1;
               tmo_d        = '0;
               core_run_d   = 1'b1;
               state_d      = S_RUN;
            end
         end
         S_DONE: begin
            core_run_d = 1'b0;
            state_d    = S_IDLE;
         end
         default: begin
            core_run_d = 1'b0;
            state_d    = S_IDLE;
         end
      endcase

      if (abort_i && (state_q == S_RUN || state_q == S_SETTLE || state_q == S_CHECK)) begin
         state_d    = S_IDLE;
         core_run_d = 1'b0;
         found_d    = 1'b0;
         tmo_err_d  = 1'b0;
      end

      done_d = (state_d == S_DONE);
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= S_IDLE;
         core_run_q   <= 1'b0;
         core_nonce_q <= 8'd0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         found_q      <= 1'b0;
         tmo_err_q    <= 1'b0;
         nonce_out_q  <= 8'd0;
         hash_out_q   <= 24'd0;
         target_q     <= 8'd0;
         tries_q      <= 8'd0;
         tmo_q        <= '0;
      end else begin
         state_q      <= state_d;
         core_run_q   <= core_run_d;
         core_nonce_q <= core_nonce_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         found_q      <= found_d;
         tmo_err_q    <= tmo_err_d;
         nonce_out_q  <= nonce_out_d;
         hash_out_q   <= hash_out_d;
         target_q     <= target_d;
         tries_q      <= tries_d;
         tmo_q        <= tmo_d;
      end
   end

   assign core_run_o    = core_run_q;
   assign core_nonce_o  = core_nonce_q;
   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign found_o       = found_q;
   assign timeout_err_o = tmo_err_q;
   assign nonce_out_o   = nonce_out_q;
   assign hash_out_o    = hash_out_q;

endmodule

// File: tb/tb_hash_nonce_ctrl.sv
// Bench for hash_nonce_ctrl: behavioural hash core plus a done-driven scoreboard.
module tb_hash_nonce_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        start_i = 1'b0;
   logic        abort_i = 1'b0;
   logic [7:0]  nonce_init_i = 8'd0;
   logic [7:0]  target_i = 8'd0;
   logic [4:0]  core_cnt_i;
   logic [7:0]  core_hash0_i, core_hash1_i, core_hash2_i;
   logic        core_run_o;
   logic [7:0]  core_nonce_o;
   logic        busy_o, done_o, found_o, timeout_err_o;
   logic [7:0]  nonce_out_o;
   logic [23:0] hash_out_o;

   hash_nonce_ctrl #(.MAX_TRIES(16), .TIMEOUT(40)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
      .nonce_init_i(nonce_init_i), .target_i(target_i), .core_cnt_i(core_cnt_i),
      .core_hash0_i(core_hash0_i), .core_hash1_i(core_hash1_i), .core_hash2_i(core_hash2_i),
      .core_run_o(core_run_o), .core_nonce_o(core_nonce_o), .busy_o(busy_o), .done_o(done_o),
      .found_o(found_o), .timeout_err_o(timeout_err_o), .nonce_out_o(nonce_out_o),
      .hash_out_o(hash_out_o)
   );

   always #5 clk_i = ~clk_i;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   // Behavioural core: counter runs while core_run, hash tracks the nonce while running.
   logic [7:0] pass_nonce = 8'h00;
   logic       cnt_hold = 1'b0;
   logic [4:0] m_cnt;
   logic [7:0] m_h0, m_h1, m_h2;
   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         m_cnt <= 5'd0; m_h0 <= 8'd0; m_h1 <= 8'd0; m_h2 <= 8'd0;
      end else begin
         m_cnt <= (core_run_o && !cnt_hold) ? m_cnt + 5'd1 : 5'd0;
         if (core_run_o) begin
            m_h2 <= (core_nonce_o == pass_nonce) ? 8'h20 : 8'hF0;
            m_h1 <= core_nonce_o ^ 8'hA5;
            m_h0 <= core_nonce_o + 8'h11;
         end
      end
   end
   assign core_cnt_i   = m_cnt;
   assign core_hash0_i = m_h0;
   assign core_hash1_i = m_h1;
   assign core_hash2_i = m_h2;

   typedef struct {
      logic        found;
      logic        tmo;
      logic [7:0]  nonce;
      logic [23:0] hash;
      logic        chk_data;
      int          due;
   } exp_t;
   exp_t sb[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk_i) begin
      if (rst_ni && done_o) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("done_cycle", cyc, e.due);
            check("found", {31'd0, found_o}, {31'd0, e.found});
            check("timeout_err", {31'd0, timeout_err_o}, {31'd0, e.tmo});
            check("busy_in_done", {31'd0, busy_o}, 32'd1);
            if (e.chk_data) begin
               check("nonce_out", {24'd0, nonce_out_o}, {24'd0, e.nonce});
               check("hash_out", {8'd0, hash_out_o}, {8'd0, e.hash});
            end
         end
      end
   end

   task automatic issue(input logic [7:0] ni, input logic [7:0] tg, input logic [7:0] pn,
                        input logic hold, input exp_t e, input int lat);
      pass_nonce   = pn;
      cnt_hold     = hold;
      nonce_init_i = ni;
      target_i     = tg;
      start_i      = 1'b1;
      e.due        = cyc + lat;
      sb.push_back(e);
      @(negedge clk_i);
      start_i = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while ((sb.size() != 0 || busy_o) && n < budget) begin
         @(negedge clk_i);
         n++;
      end
      if (n >= budget) begin
         n_vec++;
         n_err++;
         $display("FAIL wait_idle: got still busy after %0d cycles expected idle", budget);
         sb.delete();
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_core_run"}, {31'd0, core_run_o}, 32'd0);
      check({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
      check({tag, "_done"}, {31'd0, done_o}, 32'd0);
      check({tag, "_found"}, {31'd0, found_o}, 32'd0);
      check({tag, "_timeout_err"}, {31'd0, timeout_err_o}, 32'd0);
      check({tag, "_nonce_out"}, {24'd0, nonce_out_o}, 32'd0);
      check({tag, "_hash_out"}, {8'd0, hash_out_o}, 32'd0);
      check({tag, "_core_nonce"}, {24'd0, core_nonce_o}, 32'd0);
   endtask

   initial begin
      exp_t e;
      #1;
      check_reset_outputs("reset");
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
      repeat (2) @(negedge clk_i);

      // Pass on the first nonce; a start mid-RUN must be ignored; a start in DONE too.
      e = '{found: 1'b1, tmo: 1'b0, nonce: 8'h10, hash: 24'h20B521, chk_data: 1'b1, due: 0};
      issue(8'h10, 8'hFF, 8'h10, 1'b0, e, 35);
      repeat (4) @(negedge clk_i);
      nonce_init_i = 8'h77; target_i = 8'h00; start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      begin
         int n = 0;
         while (!done_o && n < 200) begin
            @(negedge clk_i);
            n++;
         end
         if (n >= 200) check("wait_done", 32'd0, 32'd1);
      end
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      check("start_in_done_busy", {31'd0, busy_o}, 32'd0);
      check("start_in_done_run", {31'd0, core_run_o}, 32'd0);
      wait_idle(50);
      repeat (3) @(negedge clk_i);

      // Pass only on nonce 0x03 from 0x00: fourth try.
      e = '{found: 1'b1, tmo: 1'b0, nonce: 8'h03, hash: 24'h20A614, chk_data: 1'b1, due: 0};
      issue(8'h00, 8'h80, 8'h03, 1'b0, e, 137);
      wait_idle(300);
      repeat (2) @(negedge clk_i);

      // target 0 never passes: full sweep exhausts with nonce wrapping.
      e = '{found: 1'b0, tmo: 1'b0, nonce: 8'h07, hash: 24'hF0A218, chk_data: 1'b1, due: 0};
      issue(8'hF8, 8'h00, 8'hF9, 1'b0, e, 545);
      wait_idle(800);
      repeat (2) @(negedge clk_i);

      // Pass on the very last permitted try, after a wrap.
      e = '{found: 1'b1, tmo: 1'b0, nonce: 8'h0D, hash: 24'h20A81E, chk_data: 1'b1, due: 0};
      issue(8'hFE, 8'h80, 8'h0D, 1'b0, e, 545);
      wait_idle(800);
      repeat (2) @(negedge clk_i);

      // Stalled core counter: timeout after 40 RUN cycles.
      e = '{found: 1'b0, tmo: 1'b1, nonce: 8'h00, hash: 24'h0, chk_data: 1'b0, due: 0};
      issue(8'h40, 8'hFF, 8'h40, 1'b1, e, 41);
      wait_idle(100);
      cnt_hold = 1'b0;
      repeat (2) @(negedge clk_i);

      // start and abort together in IDLE: abort wins.
      start_i = 1'b1; abort_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0; abort_i = 1'b0;
      check("start_abort_busy", {31'd0, busy_o}, 32'd0);
      check("start_abort_run", {31'd0, core_run_o}, 32'd0);

      // Abort on RUN cycle 10: IDLE next cycle, no done pulse.
      pass_nonce = 8'h21; nonce_init_i = 8'h21; target_i = 8'hFF;
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      check("run_busy", {31'd0, busy_o}, 32'd1);
      check("run_core_run", {31'd0, core_run_o}, 32'd1);
      check("run_core_nonce", {24'd0, core_nonce_o}, 32'h21);
      repeat (9) @(negedge clk_i);
      abort_i = 1'b1;
      @(negedge clk_i);
      abort_i = 1'b0;
      check("abort_busy", {31'd0, busy_o}, 32'd0);
      check("abort_core_run", {31'd0, core_run_o}, 32'd0);
      check("abort_found", {31'd0, found_o}, 32'd0);
      check("abort_timeout_err", {31'd0, timeout_err_o}, 32'd0);
      repeat (40) @(negedge clk_i);

      // Asynchronous reset mid-RUN.
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      repeat (8) @(negedge clk_i);
      check("pre_reset_busy", {31'd0, busy_o}, 32'd1);
      #1 rst_ni = 1'b0;
      #1;
      check_reset_outputs("midrun_reset");
      @(negedge clk_i);
      rst_ni = 1'b1;
      repeat (40) @(negedge clk_i);
      check("post_reset_idle", {31'd0, busy_o}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
